// File: rtl/ascon_loader_pkg.sv
// Shared constants for the Ascon USB block loader: register map, CONTROL bits,
// block size and FSM state encoding.
package ascon_loader_pkg;

    localparam int unsigned BLOCK_BYTES = 16;

    localparam int unsigned ADDR_AD     = 0;
    localparam int unsigned ADDR_MSG    = 1;
    localparam int unsigned ADDR_CTRL   = 2;
    localparam int unsigned ADDR_STATUS = 3;

    localparam int unsigned CTRL_COMMIT_BIT  = 0;
    localparam int unsigned CTRL_RELEASE_BIT = 1;
    localparam int unsigned CTRL_CLR_ERR_BIT = 2;

    localparam int unsigned ERR_OVERFLOW_BIT = 0;
    localparam int unsigned ERR_BUSY_WR_BIT  = 1;

    typedef enum logic [1:0] {
        ST_FILL       = 2'd0,
        ST_WAIT_READY = 2'd1,
        ST_LOAD       = 2'd2,
        ST_HOLD       = 2'd3
    } state_t;

endpackage

// File: rtl/ascon_block_stage.sv
// One staging buffer: byte-lane writable block (byte 0 in the MSB lane) plus a
// high-water count of the highest byte index written.
module ascon_block_stage
    import ascon_loader_pkg::*;
#(
    parameter int unsigned BYTES = BLOCK_BYTES,
    localparam int unsigned IDX_W = $clog2(BYTES),
    localparam int unsigned CNT_W = $clog2(BYTES + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               wr_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [7:0]         data_i,
    output logic [8*BYTES-1:0] block_o,
    output logic [CNT_W-1:0]   count_o
);

    logic [8*BYTES-1:0] block_q, block_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   high_water;

    always_comb begin
        block_d    = block_q;
        count_d    = count_q;
        high_water = CNT_W'(idx_i) + CNT_W'(1);
        if (high_water > CNT_W'(BYTES)) begin
            high_water = CNT_W'(BYTES);
        end
        if (clr_i) begin
            block_d = '0;
            count_d = '0;
        end else if (wr_i) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (idx_i == IDX_W'(b)) begin
                    block_d[(BYTES-1-b)*8 +: 8] = data_i;
                end
            end
            if (high_water > count_q) begin
                count_d = high_water;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            block_q <= '0;
            count_q <= '0;
        end else begin
            block_q <= block_d;
            count_q <= count_d;
        end
    end

    assign block_o = block_q;
    assign count_o = count_q;

endmodule

// File: rtl/ascon_usb_block_loader.sv
// USB register front end that stages Ascon-128a AD and message blocks and hands
// them to the core with a single-cycle load strobe once committed.
module ascon_usb_block_loader
    import ascon_loader_pkg::*;
#(
    parameter int unsigned pBYTECNT_SIZE = 7,
    parameter int unsigned pADDR_WIDTH   = 21,
    parameter int unsigned pBLOCK_BYTES  = BLOCK_BYTES,
    localparam int unsigned REG_ADDR_W   = pADDR_WIDTH - pBYTECNT_SIZE,
    localparam int unsigned IDX_W        = $clog2(pBLOCK_BYTES),
    localparam int unsigned CNT_W        = $clog2(pBLOCK_BYTES + 1)
) (
    input  logic                      usb_clk_buf,
    input  logic                      resetn,
    input  logic [REG_ADDR_W-1:0]     reg_address,
    input  logic [pBYTECNT_SIZE-1:0]  reg_bytecnt,
    input  logic                      reg_write,
    input  logic                      reg_read,
    input  logic [7:0]                write_data,
    output logic [7:0]                read_data,
    input  logic                      I_core_ready,
    output logic [8*pBLOCK_BYTES-1:0] O_ad_block,
    output logic [8*pBLOCK_BYTES-1:0] O_msg_block,
    output logic [CNT_W-1:0]          O_valid_bytes_ad,
    output logic [CNT_W-1:0]          O_valid_bytes_msg,
    output logic                      O_load,
    output logic                      O_busy,
    output logic [1:0]                O_err
);

    // Reset asserts asynchronously but releases only after two clean edges.
    logic rst_meta_q, rst_sync_q;

    always_ff @(posedge usb_clk_buf or negedge resetn) begin
        if (!resetn) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    state_t     state_q, state_d;
    logic [1:0] err_q, err_d;
    logic       load_q, load_d;
    logic       busy_q, busy_d;

    logic ctrl_wr_c, buf_wr_c, idx_ok_c;
    logic sel_ad_c, sel_msg_c;
    logic ad_wr_c, msg_wr_c, clr_c;

    assign sel_ad_c  = reg_address == REG_ADDR_W'(ADDR_AD);
    assign sel_msg_c = reg_address == REG_ADDR_W'(ADDR_MSG);
    assign ctrl_wr_c = reg_write && (reg_address == REG_ADDR_W'(ADDR_CTRL));
    assign buf_wr_c  = reg_write && (sel_ad_c || sel_msg_c);
    assign idx_ok_c  = reg_bytecnt < pBYTECNT_SIZE'(pBLOCK_BYTES);

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        ad_wr_c  = 1'b0;
        msg_wr_c = 1'b0;
        clr_c    = 1'b0;

        case (state_q)
            ST_FILL: begin
                // Release wins over commit when both arrive in one byte.
                if (ctrl_wr_c && write_data[CTRL_RELEASE_BIT]) begin
                    clr_c = 1'b1;
                end else if (ctrl_wr_c && write_data[CTRL_COMMIT_BIT]) begin
                    state_d = ST_WAIT_READY;
                end
                if (buf_wr_c) begin
                    if (idx_ok_c) begin
                        ad_wr_c  = sel_ad_c;
                        msg_wr_c = sel_msg_c;
                    end else begin
                        err_d[ERR_OVERFLOW_BIT] = 1'b1;
                    end
                end
            end
            ST_WAIT_READY: begin
                if (I_core_ready) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (ctrl_wr_c && write_data[CTRL_RELEASE_BIT]) begin
                    clr_c   = 1'b1;
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        if (buf_wr_c && (state_q != ST_FILL)) begin
            err_d[ERR_BUSY_WR_BIT] = 1'b1;
        end
        if (ctrl_wr_c && write_data[CTRL_CLR_ERR_BIT]) begin
            err_d = 2'b00;
        end

        load_d = state_d == ST_LOAD;
        busy_d = state_d != ST_FILL;
    end

    always_ff @(posedge usb_clk_buf or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= ST_FILL;
            err_q   <= 2'b00;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
        end
    end

    ascon_block_stage #(.BYTES(pBLOCK_BYTES)) u_ad_stage (
        .clk_i   (usb_clk_buf),
        .rst_ni  (rst_sync_q),
        .clr_i   (clr_c),
        .wr_i    (ad_wr_c),
        .idx_i   (IDX_W'(reg_bytecnt)),
        .data_i  (write_data),
        .block_o (O_ad_block),
        .count_o (O_valid_bytes_ad)
    );

    ascon_block_stage #(.BYTES(pBLOCK_BYTES)) u_msg_stage (
        .clk_i   (usb_clk_buf),
        .rst_ni  (rst_sync_q),
        .clr_i   (clr_c),
        .wr_i    (msg_wr_c),
        .idx_i   (IDX_W'(reg_bytecnt)),
        .data_i  (write_data),
        .block_o (O_msg_block),
        .count_o (O_valid_bytes_msg)
    );

    always_comb begin
        read_data = 8'h00;
        if (reg_read && (reg_address == REG_ADDR_W'(ADDR_STATUS))) begin
            if (reg_bytecnt == pBYTECNT_SIZE'(0)) begin
                read_data = {3'b000, err_q, state_q, busy_q};
            end else if (reg_bytecnt == pBYTECNT_SIZE'(1)) begin
                read_data = 8'(O_valid_bytes_ad);
            end else if (reg_bytecnt == pBYTECNT_SIZE'(2)) begin
                read_data = 8'(O_valid_bytes_msg);
            end
        end
    end

    assign O_load = load_q;
    assign O_busy = busy_q;
    assign O_err  = err_q;

endmodule

// File: tb/tb_ascon_usb_block_loader.sv
// Directed self-checking bench for ascon_usb_block_loader.
module tb_ascon_usb_block_loader;

    logic         usb_clk_buf = 1'b0;
    logic         resetn      = 1'b0;
    logic [13:0]  reg_address = '0;
    logic [6:0]   reg_bytecnt = '0;
    logic         reg_write   = 1'b0;
    logic         reg_read    = 1'b0;
    logic [7:0]   write_data  = '0;
    logic [7:0]   read_data;
    logic         I_core_ready = 1'b0;
    logic [127:0] O_ad_block, O_msg_block;
    logic [4:0]   O_valid_bytes_ad, O_valid_bytes_msg;
    logic         O_load, O_busy;
    logic [1:0]   O_err;

    int tests = 0;
    int fails = 0;

    always #5 usb_clk_buf = ~usb_clk_buf;

    ascon_usb_block_loader dut (
        .usb_clk_buf       (usb_clk_buf),
        .resetn            (resetn),
        .reg_address       (reg_address),
        .reg_bytecnt       (reg_bytecnt),
        .reg_write         (reg_write),
        .reg_read          (reg_read),
        .write_data        (write_data),
        .read_data         (read_data),
        .I_core_ready      (I_core_ready),
        .O_ad_block        (O_ad_block),
        .O_msg_block       (O_msg_block),
        .O_valid_bytes_ad  (O_valid_bytes_ad),
        .O_valid_bytes_msg (O_valid_bytes_msg),
        .O_load            (O_load),
        .O_busy            (O_busy),
        .O_err             (O_err)
    );

    task automatic wr(input logic [13:0] a, input logic [6:0] i, input logic [7:0] d);
        @(negedge usb_clk_buf);
        reg_address = a;
        reg_bytecnt = i;
        write_data  = d;
        reg_write   = 1'b1;
        @(negedge usb_clk_buf);
        reg_write   = 1'b0;
    endtask

    task automatic rd_status(input logic [6:0] i, output logic [7:0] d);
        reg_address = 14'd3;
        reg_bytecnt = i;
        reg_read    = 1'b1;
        #1;
        d = read_data;
        reg_read    = 1'b0;
    endtask

    task automatic release_reset();
        resetn = 1'b1;
        repeat (3) @(negedge usb_clk_buf);
    endtask

    task automatic test_reset();
        logic [7:0] st;
        resetn = 1'b0;
        repeat (2) @(negedge usb_clk_buf);
        tests++;
        if ({O_ad_block, O_msg_block, O_valid_bytes_ad, O_valid_bytes_msg, O_load, O_busy, O_err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: ad=%h msg=%h load=%b busy=%b err=%b, required all zero",
                     O_ad_block, O_msg_block, O_load, O_busy, O_err);
        end
        release_reset();
        rd_status(7'd0, st);
        tests++;
        if (st !== 8'h00) begin
            fails++;
            $display("FAIL reset_status: got %h, required 00", st);
        end
    endtask

    // Commit then expect O_load only in the cycle two edges after the commit edge.
    task automatic commit_and_check_load(input string tag);
        logic [2:0] seen;
        I_core_ready = 1'b1;
        wr(14'd2, 7'd0, 8'h01);
        seen[0] = O_load;
        @(negedge usb_clk_buf);
        seen[1] = O_load;
        @(negedge usb_clk_buf);
        seen[2] = O_load;
        tests++;
        if (seen !== 3'b010 || O_busy !== 1'b1) begin
            fails++;
            $display("FAIL %s_load_timing: load seq=%b busy=%b, required 010 busy=1", tag, seen, O_busy);
        end
    endtask

    task automatic test_ad_block();
        logic [7:0] st;
        for (int i = 0; i < 5; i++) wr(14'd0, 7'(i), 8'(i + 1));
        tests++;
        if (O_ad_block !== 128'h0102_0304_0500_0000_0000_0000_0000_0000 || O_valid_bytes_ad !== 5'd5) begin
            fails++;
            $display("FAIL ad_block: got %h cnt=%0d, required 0102030405.. cnt=5", O_ad_block, O_valid_bytes_ad);
        end
        commit_and_check_load("ad");
        rd_status(7'd0, st);
        tests++;
        if (st !== 8'h07) begin
            fails++;
            $display("FAIL hold_status: got %h, required 07", st);
        end
        wr(14'd2, 7'd0, 8'h02);
        tests++;
        if (O_ad_block !== '0 || O_valid_bytes_ad !== 5'd0 || O_busy !== 1'b0) begin
            fails++;
            $display("FAIL release_clear: ad=%h cnt=%0d busy=%b, required 0 0 0", O_ad_block, O_valid_bytes_ad, O_busy);
        end
    endtask

    task automatic test_msg_last_byte();
        logic [7:0] st;
        wr(14'd1, 7'd15, 8'hAA);
        tests++;
        if (O_msg_block !== 128'h0000_0000_0000_0000_0000_0000_0000_00AA || O_valid_bytes_msg !== 5'd16) begin
            fails++;
            $display("FAIL msg_byte15: got %h cnt=%0d, required ..00AA cnt=16", O_msg_block, O_valid_bytes_msg);
        end
        rd_status(7'd2, st);
        tests++;
        if (st !== 8'h10) begin
            fails++;
            $display("FAIL msg_count_read: got %h, required 10", st);
        end
        wr(14'd1, 7'd3, 8'h5C);
        tests++;
        if (O_valid_bytes_msg !== 5'd16 || O_msg_block !== 128'h0000_005C_0000_0000_0000_0000_0000_00AA) begin
            fails++;
            $display("FAIL msg_high_water: got %h cnt=%0d, required 5C at byte3 cnt=16", O_msg_block, O_valid_bytes_msg);
        end
        wr(14'd2, 7'd0, 8'h02);
    endtask

    task automatic test_wait_ready();
        int bad = 0;
        logic seen;
        I_core_ready = 1'b0;
        wr(14'd2, 7'd0, 8'h01);
        for (int c = 0; c < 10; c++) begin
            if (O_load !== 1'b0 || O_busy !== 1'b1) bad++;
            @(negedge usb_clk_buf);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL wait_hold_off: %0d bad cycles, required load=0 busy=1 every cycle", bad);
        end
        I_core_ready = 1'b1;
        seen = O_load;
        @(negedge usb_clk_buf);
        tests++;
        if (seen !== 1'b0 || O_load !== 1'b1 || O_busy !== 1'b1) begin
            fails++;
            $display("FAIL wait_load: before=%b after=%b busy=%b, required 0 1 1", seen, O_load, O_busy);
        end
        @(negedge usb_clk_buf);
        tests++;
        if (O_load !== 1'b0) begin
            fails++;
            $display("FAIL wait_load_width: load=%b, required 0", O_load);
        end
        wr(14'd2, 7'd0, 8'h02);
    endtask

    task automatic test_errors();
        wr(14'd0, 7'd16, 8'h55);
        tests++;
        if (O_ad_block !== '0 || O_valid_bytes_ad !== 5'd0 || O_err !== 2'b01) begin
            fails++;
            $display("FAIL err_overflow: ad=%h cnt=%0d err=%b, required 0 0 01", O_ad_block, O_valid_bytes_ad, O_err);
        end
        commit_and_check_load("err");
        wr(14'd1, 7'd0, 8'h77);
        tests++;
        if (O_err !== 2'b11 || O_msg_block !== '0 || O_valid_bytes_msg !== 5'd0) begin
            fails++;
            $display("FAIL err_busy_write: err=%b msg=%h, required 11 and 0", O_err, O_msg_block);
        end
        wr(14'd2, 7'd0, 8'h04);
        tests++;
        if (O_err !== 2'b00 || O_busy !== 1'b1) begin
            fails++;
            $display("FAIL err_clear: err=%b busy=%b, required 00 1", O_err, O_busy);
        end
        wr(14'd2, 7'd0, 8'h02);
    endtask

    task automatic test_reset_in_hold();
        logic [7:0] st;
        wr(14'd0, 7'd0, 8'h11);
        commit_and_check_load("pre_rst");
        @(negedge usb_clk_buf);
        resetn = 1'b0;
        #1;
        tests++;
        if ({O_ad_block, O_valid_bytes_ad, O_load, O_busy, O_err} !== '0) begin
            fails++;
            $display("FAIL reset_hold: ad=%h cnt=%0d busy=%b, required all zero", O_ad_block, O_valid_bytes_ad, O_busy);
        end
        release_reset();
        rd_status(7'd0, st);
        tests++;
        if (st !== 8'h00) begin
            fails++;
            $display("FAIL reset_hold_state: got %h, required 00", st);
        end
        wr(14'd0, 7'd0, 8'h22);
        commit_and_check_load("post_rst");
        tests++;
        if (O_ad_block !== 128'h2200_0000_0000_0000_0000_0000_0000_0000 || O_valid_bytes_ad !== 5'd1) begin
            fails++;
            $display("FAIL post_reset_block: got %h cnt=%0d, required 22.. cnt=1", O_ad_block, O_valid_bytes_ad);
        end
        wr(14'd2, 7'd0, 8'h02);
    endtask

    task automatic test_commit_release();
        logic [7:0] st;
        int loads = 0;
        I_core_ready = 1'b1;
        wr(14'd0, 7'd2, 8'h33);
        wr(14'd1, 7'd0, 8'h44);
        wr(14'd2, 7'd0, 8'h03);
        for (int c = 0; c < 4; c++) begin
            if (O_load !== 1'b0) loads++;
            @(negedge usb_clk_buf);
        end
        rd_status(7'd0, st);
        tests++;
        if (O_ad_block !== '0 || O_msg_block !== '0 || O_valid_bytes_ad !== 5'd0 ||
            O_valid_bytes_msg !== 5'd0 || loads != 0 || st !== 8'h00) begin
            fails++;
            $display("FAIL commit_release: ad=%h msg=%h loads=%0d status=%h, required 0 0 0 00",
                     O_ad_block, O_msg_block, loads, st);
        end
    endtask

    task automatic test_empty_commit();
        commit_and_check_load("empty");
        wr(14'd2, 7'd0, 8'h02);
    endtask

    initial begin
        test_reset();
        test_ad_block();
        test_msg_last_byte();
        test_wait_ready();
        test_errors();
        test_reset_in_hold();
        test_commit_release();
        test_empty_commit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
